// File: rtl/fsm_puzzle.sv
// Sequence-lock controller: unlocks on entry codes 1,2,3,4 on consecutive edges.
// Optional lockout after three consecutive errors when FSMPUZZLE_LOCKOUT_EN is defined.
module fsm_puzzle (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] in_pattern,
    output logic [6:0] seg,
    output logic       green_led,
    output logic       red_led,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        St0    = 4'd0,
        St1    = 4'd1,
        St2    = 4'd2,
        St3    = 4'd3,
        St4    = 4'd4,
        StLock = 4'd5
    } state_e;

    state_e state_q, state_d;
    logic   err_q, err_d;
    logic   wrong;

`ifdef FSMPUZZLE_LOCKOUT_EN
    logic [1:0] err_cnt_q, err_cnt_d;
    logic [3:0] timer_q, timer_d;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= St0;
            err_q   <= 1'b0;
`ifdef FSMPUZZLE_LOCKOUT_EN
            err_cnt_q <= 2'd0;
            timer_q   <= 4'd0;
`endif
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
`ifdef FSMPUZZLE_LOCKOUT_EN
            err_cnt_q <= err_cnt_d;
            timer_q   <= timer_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        wrong   = 1'b0;
`ifdef FSMPUZZLE_LOCKOUT_EN
        err_cnt_d = err_cnt_q;
        timer_d   = timer_q;
`endif
        // Code 0 means "no entry": hold without flagging an error.
        case (state_q)
            St0: begin
                if (in_pattern == 4'h1) state_d = St1;
                else if (in_pattern != 4'h0) wrong = 1'b1;
            end
            St1: begin
                if (in_pattern == 4'h2) state_d = St2;
                else if (in_pattern != 4'h0) wrong = 1'b1;
            end
            St2: begin
                if (in_pattern == 4'h3) state_d = St3;
                else if (in_pattern != 4'h0) wrong = 1'b1;
            end
            St3: begin
                if (in_pattern == 4'h4) state_d = St4;
                else if (in_pattern != 4'h0) wrong = 1'b1;
            end
            St4: state_d = St0;
`ifdef FSMPUZZLE_LOCKOUT_EN
            StLock: begin
                if (timer_q == 4'd15) begin
                    state_d   = St0;
                    err_cnt_d = 2'd0;
                end else begin
                    timer_d = timer_q + 4'd1;
                end
            end
`endif
            default: state_d = St0;
        endcase

        if (wrong) begin
            err_d   = 1'b1;
            state_d = St0;
`ifdef FSMPUZZLE_LOCKOUT_EN
            if (err_cnt_q == 2'd2) begin
                state_d = StLock;
                timer_d = 4'd0;
            end else begin
                err_cnt_d = err_cnt_q + 2'd1;
            end
`endif
        end

`ifdef FSMPUZZLE_LOCKOUT_EN
        if (state_d == St4) err_cnt_d = 2'd0;
`endif
    end

    always_comb begin
        case (state_q)
            St0:     seg = 7'h3F;
            St1:     seg = 7'h06;
            St2:     seg = 7'h5B;
            St3:     seg = 7'h4F;
            St4:     seg = 7'h66;
            StLock:  seg = 7'h38;
            default: seg = 7'h00;
        endcase
    end

    assign state     = state_q;
    assign green_led = (state_q == St4);
`ifdef FSMPUZZLE_LOCKOUT_EN
    assign red_led   = err_q | (state_q == StLock);
`else
    assign red_led   = err_q;
`endif

endmodule

// File: tb/tb_fsm_puzzle.sv
// Directed self-checking bench for fsm_puzzle; covers lockout when FSMPUZZLE_LOCKOUT_EN is defined.
module tb_fsm_puzzle;

    logic       clk;
    logic       rst;
    logic [3:0] in_pattern;
    logic [6:0] seg;
    logic       green_led;
    logic       red_led;
    logic [3:0] state;

    int n_checks = 0;
    int n_pass   = 0;

    fsm_puzzle dut (
        .clk        (clk),
        .rst        (rst),
        .in_pattern (in_pattern),
        .seg        (seg),
        .green_led  (green_led),
        .red_led    (red_led),
        .state      (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    // Drive one code, let one rising edge sample it, then settle.
    task automatic apply(input logic [3:0] p);
        in_pattern = p;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] st, input logic [6:0] sg,
                              input logic gr, input logic rd);
        check({tag, ".state"}, 32'(state), 32'(st));
        check({tag, ".seg"}, 32'(seg), 32'(sg));
        check({tag, ".green"}, 32'(green_led), 32'(gr));
        check({tag, ".red"}, 32'(red_led), 32'(rd));
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        in_pattern = 4'h0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rst        = 1'b0;
        in_pattern = 4'h0;

        do_reset();
        expect_out("reset", 4'd0, 7'h3F, 1'b0, 1'b0);

        apply(4'h1); expect_out("unlock1", 4'd1, 7'h06, 1'b0, 1'b0);
        apply(4'h2); expect_out("unlock2", 4'd2, 7'h5B, 1'b0, 1'b0);
        apply(4'h3); expect_out("unlock3", 4'd3, 7'h4F, 1'b0, 1'b0);
        apply(4'h4); expect_out("unlock4", 4'd4, 7'h66, 1'b1, 1'b0);
        apply(4'h0); expect_out("unlock_done", 4'd0, 7'h3F, 1'b0, 1'b0);

        apply(4'hF); expect_out("idle_wrong", 4'd0, 7'h3F, 1'b0, 1'b1);
        apply(4'h0); expect_out("idle_wrong_clr", 4'd0, 7'h3F, 1'b0, 1'b0);

        apply(4'h1); expect_out("mid_1", 4'd1, 7'h06, 1'b0, 1'b0);
        apply(4'hF); expect_out("mid_wrong", 4'd0, 7'h3F, 1'b0, 1'b1);
        apply(4'h0); expect_out("mid_wrong_clr", 4'd0, 7'h3F, 1'b0, 1'b0);

        apply(4'h1); apply(4'h2);
        for (int i = 0; i < 3; i++) begin
            apply(4'h0);
            expect_out("hold_zero", 4'd2, 7'h5B, 1'b0, 1'b0);
        end
        apply(4'h3); expect_out("hold_3", 4'd3, 7'h4F, 1'b0, 1'b0);
        apply(4'h4); expect_out("hold_4", 4'd4, 7'h66, 1'b1, 1'b0);
        // S4 returns to idle even with a non-zero code, without an error.
        apply(4'h7); expect_out("s4_exit", 4'd0, 7'h3F, 1'b0, 1'b0);

        apply(4'h1); apply(4'h2); apply(4'h3);
        check("pre_async.state", 32'(state), 32'd3);
        #2 rst = 1'b0;
        #1;
        expect_out("async_rst", 4'd0, 7'h3F, 1'b0, 1'b0);
        #1 rst = 1'b1;
        apply(4'h1); expect_out("post_rst_1", 4'd1, 7'h06, 1'b0, 1'b0);
        apply(4'h3); expect_out("post_rst_wrong", 4'd0, 7'h3F, 1'b0, 1'b1);

        do_reset();
        apply(4'hF); apply(4'hF); apply(4'hF);
`ifdef FSMPUZZLE_LOCKOUT_EN
        expect_out("lock_enter", 4'd5, 7'h38, 1'b0, 1'b1);
        for (int i = 1; i < 16; i++) begin
            apply(4'h1);
            expect_out("lock_hold", 4'd5, 7'h38, 1'b0, 1'b1);
        end
        apply(4'h0); expect_out("lock_exit", 4'd0, 7'h3F, 1'b0, 1'b0);
        apply(4'hF); expect_out("lock_cnt_clr", 4'd0, 7'h3F, 1'b0, 1'b1);
`else
        expect_out("triple_wrong", 4'd0, 7'h3F, 1'b0, 1'b1);
        apply(4'h0); expect_out("triple_wrong_clr", 4'd0, 7'h3F, 1'b0, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
